// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors
// and selectable registered or first-word-fall-through read data.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             rd_acc;
    logic             wr_acc;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // A write at full only lands when a pop frees the slot on the same edge.
    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // A fresh error on the clearing edge keeps its flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow && !clr_err) || (w_en && !wr_acc);
            underflow <= (underflow && !clr_err) || (r_en && !rd_acc);
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
        logic [WIDTH-1:0] rd_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_q <= '0;
            end else if (rd_acc) begin
                rd_q <= mem[rd_ptr];
            end
        end

        assign data_out = rd_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised and directed checks of both read modes against a queue model.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] cnt0, cnt1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic [7:0] m_last;
    logic       m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u_std (
        .clk(clk), .reset(reset), .data_in(data_in), .w_en(w_en),
        .r_en(r_en), .clr_err(clr_err), .data_out(dout0),
        .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0),
        .underflow(unf0)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(reset), .data_in(data_in), .w_en(w_en),
        .r_en(r_en), .clr_err(clr_err), .data_out(dout1),
        .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1),
        .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic r,
                              input logic [7:0] d, input logic c);
        logic rd_ok, wr_ok;
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < 16) || rd_ok);
        if (rd_ok) m_last = q.pop_front();
        if (wr_ok) q.push_back(d);
        m_ovf = (m_ovf && !c) || (w && !wr_ok);
        m_unf = (m_unf && !c) || (r && !rd_ok);
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count0", 32'(cnt0), 32'(n));
        chk("count1", 32'(cnt1), 32'(n));
        chk("full0", 32'(full0), 32'(n == 16));
        chk("full1", 32'(full1), 32'(n == 16));
        chk("empty0", 32'(empty0), 32'(n == 0));
        chk("empty1", 32'(empty1), 32'(n == 0));
        chk("afull0", 32'(af0), 32'(n >= 14));
        chk("afull1", 32'(af1), 32'(n >= 14));
        chk("aempty0", 32'(ae0), 32'(n <= 2));
        chk("aempty1", 32'(ae1), 32'(n <= 2));
        chk("ovf0", 32'(ovf0), 32'(m_ovf));
        chk("ovf1", 32'(ovf1), 32'(m_ovf));
        chk("unf0", 32'(unf0), 32'(m_unf));
        chk("unf1", 32'(unf1), 32'(m_unf));
        chk("dout_std", 32'(dout0), 32'(m_last));
        if (n > 0) chk("dout_fwft", 32'(dout1), 32'(q[0]));
    endtask

    task automatic cycle(input logic w, input logic r,
                         input logic [7:0] d, input logic c);
        w_en = w;
        r_en = r;
        data_in = d;
        clr_err = c;
        @(posedge clk);
        model_step(w, r, d, c);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        clr_err = 1'b0;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 1, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] exp_rd[$];
        model_reset();

        #12;
        check_all();
        chk("rst_dout1", 32'(dout1), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // fill and overflow
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 8'(i), 0);
            if (i == 13) chk("af_at14", 32'(af0), 32'h1);
        end
        chk("full_at16", 32'(full0), 32'h1);
        cycle(1, 0, 8'hFF, 0);
        chk("ovf_17th", 32'(ovf0), 32'h1);
        chk("cnt_17th", 32'(cnt0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 8'h00, 0);
            chk("fill_rd", 32'(dout0), 32'(i));
        end
        chk("fill_empty", 32'(empty0), 32'h1);
        chk("fill_aempty", 32'(ae0), 32'h1);
        cycle(0, 0, 8'h00, 1);

        // wrap-around
        for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i), 0);
        cycle(0, 1, 8'h00, 0);
        cycle(0, 1, 8'h00, 0);
        chk("wrap_cnt14", 32'(cnt0), 32'd14);
        cycle(1, 0, 8'h34, 0);
        cycle(1, 0, 8'h35, 0);
        chk("wrap_cnt16", 32'(cnt0), 32'd16);
        for (int i = 2; i < 16; i++) exp_rd.push_back(8'(i));
        exp_rd.push_back(8'h34);
        exp_rd.push_back(8'h35);
        foreach (exp_rd[i]) begin
            cycle(0, 1, 8'h00, 0);
            chk("wrap_rd", 32'(dout0), 32'(exp_rd[i]));
        end
        chk("wrap_cnt0", 32'(cnt0), 32'd0);

        // simultaneous access at full and at empty
        for (int i = 0; i < 16; i++) cycle(1, 0, 8'(8'h40 + i), 0);
        cycle(1, 1, 8'hAA, 0);
        chk("sim_full_cnt", 32'(cnt0), 32'd16);
        chk("sim_full_dout", 32'(dout0), 32'h40);
        chk("sim_full_ovf", 32'(ovf0), 32'h0);
        drain();
        cycle(1, 1, 8'h56, 0);
        chk("sim_empty_unf", 32'(unf0), 32'h1);
        chk("sim_empty_cnt", 32'(cnt0), 32'd1);
        cycle(0, 1, 8'h00, 0);
        chk("sim_empty_rd", 32'(dout0), 32'h56);
        cycle(0, 0, 8'h00, 1);

        // first-word-fall-through
        cycle(1, 0, 8'h12, 0);
        chk("fwft_first", 32'(dout1), 32'h12);
        cycle(1, 0, 8'h78, 0);
        chk("fwft_hold", 32'(dout1), 32'h12);
        cycle(0, 1, 8'h00, 0);
        chk("fwft_pop1", 32'(dout1), 32'h78);
        cycle(0, 1, 8'h00, 0);
        chk("fwft_empty", 32'(empty1), 32'h1);

        // reset between edges
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h90 + i), 0);
        cycle(0, 1, 8'h00, 0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_empty", 32'(empty0), 32'h1);
        chk("rst_mid_cnt", 32'(cnt0), 32'd0);
        chk("rst_mid_dout", 32'(dout0), 32'h0);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        cycle(1, 0, 8'hCD, 0);
        cycle(0, 1, 8'h00, 0);
        chk("rst_rel_rd", 32'(dout0), 32'hCD);

        // error clear
        cycle(0, 1, 8'h00, 0);
        for (int i = 0; i < 17; i++) cycle(1, 0, 8'(i), 0);
        chk("err_both_o", 32'(ovf0), 32'h1);
        chk("err_both_u", 32'(unf0), 32'h1);
        cycle(0, 0, 8'h00, 1);
        chk("clr_ovf", 32'(ovf0), 32'h0);
        chk("clr_unf", 32'(unf0), 32'h0);
        cycle(1, 0, 8'hEE, 1);
        chk("clr_set_wins", 32'(ovf0), 32'h1);
        drain();

        // biased random traffic
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 64) % 2 == 0) ? 70 : 30;
            cycle($urandom_range(99) < wp,
                  $urandom_range(99) < (100 - wp),
                  8'($urandom),
                  $urandom_range(31) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It is the drop-in successor to the team's basic synchronous FIFO: it keeps the same core handshake and adds the status and error reporting that upstream producers and downstream arbiters need for flow control.

## Interface

- Clocking: one clock, `clk`; reset is asynchronous and active-low, named `reset`.

**Parameters**

- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 16: number of entries. Must be a power of 2 and at least 4.
- `AF_THRESH`, default DEPTH-2: `almost_full` asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- `AE_THRESH`, default 2: `almost_empty` asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.
- `FWFT`, default 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.

**Ports**

- `clk` in, 1: clock, rising-edge.
- `reset` in, 1: asynchronous active-low reset.
- `data_in` in, WIDTH: write data.
- `w_en` in, 1: write request.
- `r_en` in, 1: read request (pop).
- `clr_err` in, 1: synchronous clear of `overflow` and `underflow`.
- `data_out` out, WIDTH: read data.
- `full` out, 1: count == DEPTH.
- `empty` out, 1: count == 0.
- `almost_full` out, 1: count >= AF_THRESH.
- `almost_empty` out, 1: count <= AE_THRESH.
- `count` out, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out, 1: sticky; a write was rejected.
- `underflow` out, 1: sticky; a read was rejected.

## Operation

- **Storage:** register array of DEPTH × WIDTH words.
- **Pointers:**
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
  - Occupancy is held in a separate registered `count`.
- **Read accept:** `rd_acc = r_en && !empty`.
- **Write accept:** `wr_acc = w_en && (!full || rd_acc)`. A write at full is accepted only when it is paired with an accepted read.
- **Simultaneous read and write:**
  - At empty: the read is rejected and `underflow` sets; the write is accepted, so count becomes 1.
  - At full: both are accepted; count stays DEPTH and no overflow is flagged.
- **Count update:** +1 on write only, −1 on read only, unchanged on both or neither.
- **Standard mode (FWFT=0):**
  - On `rd_acc`, `data_out` registers `mem[rd_ptr]` at that edge.
  - Otherwise `data_out` holds its previous value.
- **FWFT mode (FWFT=1):**
  - `data_out` = `mem[rd_ptr]` at all times.
  - The value is valid whenever `empty` = 0.
  - `r_en` pops the head entry.
- **Error flags:**
  - `overflow` sets on any edge where `w_en && !wr_acc`.
  - `underflow` sets on any edge where `r_en && !rd_acc`.
  - A rejected access never changes the pointers, the count or the memory.
  - `clr_err` clears both flags at the edge. If a new error occurs on the same edge, set wins.
- **Reset (`reset` low, asynchronous, any time including mid-transfer):**
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `data_out` = 0, `empty` = 1, `almost_empty` = 1.
  - `full`, `almost_full`, `overflow` and `underflow` = 0.
  - Memory contents are not cleared.

## Timing

- All flags and `count` are registered, or decoded directly from the registered count. They update at the same rising edge that accepts the access.
- **Write-to-read latency:**
  - A word written at edge N makes `empty` deassert at N.
  - Standard mode: a read requested in cycle N+1 returns the word at edge N+1.
  - FWFT mode: the word appears on `data_out` just after edge N, with no `r_en` needed.
- **Threshold flags:**
  - `almost_full` asserts at the edge where count reaches AF_THRESH.
  - `almost_empty` deasserts at the edge where count reaches AE_THRESH+1.
- **Throughput:** one write and one read per cycle, sustained, at any occupancy from 1 to DEPTH.
- **Reset release:** the first access is accepted at the first rising edge after `reset` goes high.

## Test plan

All scenarios use DEPTH=16.

- **Fill and overflow (FWFT=0).** Write 0x00..0x0F on consecutive cycles.
  - `almost_full` = 1 after the 14th write; `full` = 1 after the 16th.
  - A 17th write of 0xFF with `r_en`=0 sets `overflow`=1 and count stays 16.
  - 16 reads then return 0x00..0x0F in order; `empty`=1 and `almost_empty`=1 at the end.
- **Wrap-around.** Write 0x00..0x0F, read 2, write 0x34 and 0x35.
  - The remaining reads return 0x02..0x0F, then 0x34, then 0x35.
  - Count tracks 16→14→16→0.
- **Simultaneous access.**
  - At full: w_en=r_en=1 with `data_in`=0xAA gives count=16, `data_out`=oldest word and `overflow`=0.
  - At empty: w_en=r_en=1 with 0x56 gives `underflow`=1 and count=1; the next read returns 0x56.
- **FWFT=1.** Write 0x12 then 0x78.
  - `data_out`=0x12 one cycle after the first write, with no `r_en`.
  - After one `r_en`, `data_out`=0x78.
  - After a second `r_en`, `empty`=1.
- **Reset mid-operation.** Write 5 words, then pull `reset` low between clock edges.
  - Immediately (before the next edge): `empty`=1, count=0 and `data_out`=0.
  - After release, a write of 0xCD followed by a read returns 0xCD.
- **Error clear.** With `overflow` and `underflow` both set, pulse `clr_err` for one cycle.
  - Both flags read 0 after the edge.
  - `clr_err` asserted together with an overflowing write leaves `overflow`=1.
